// File: rtl/mac_pkg.sv
// Package shared by the mac_accum_8 slice.
// Contents: the FSM state type (ST_ACC / ST_DONE), the operand and product
// widths, and cnt_w(), which sizes the term counter.
// Optional feature macro (used in mac_accum_8.sv): MAC_SATURATE_EN.
package mac_pkg;

   localparam int OP_W   = 8;
   localparam int PROD_W = 16;

   typedef enum logic [0:0] {
      ST_ACC  = 1'b0,
      ST_DONE = 1'b1
   } state_e;

   // Width of a counter that must hold 0..n-1. It never drops below 1 bit,
   // so N_TERMS=1 still gets a legal vector.
   function automatic int cnt_w(input int n);
      if (n <= 1) begin
         return 1;
      end else begin
         return $clog2(n);
      end
   endfunction

endpackage

// File: rtl/multi_8.sv
// multi_8: combinational 8x8 unsigned array multiplier.
// Ports:
//   a [OP_W-1:0]   in  : multiplicand
//   b [OP_W-1:0]   in  : multiplier
//   p [PROD_W-1:0] out : a*b, full 16-bit product
// Macros: none.
module multi_8
   import mac_pkg::*;
(
   input  logic [OP_W-1:0]   a,
   input  logic [OP_W-1:0]   b,
   output logic [PROD_W-1:0] p
);

   logic [PROD_W-1:0] prod_s;

   // Shift-and-add array: each multiplier bit that is set adds one shifted
   // copy of the multiplicand.
   always_comb begin
      prod_s = '0;
      for (int i = 0; i < OP_W; i++) begin
         if (b[i]) begin
            prod_s = prod_s + (PROD_W'(a) << i);
         end else begin
            prod_s = prod_s;
         end
      end
   end

   assign p = prod_s;

endmodule

// File: rtl/mac_accum_8.sv
// mac_accum_8: multiply-accumulate stage that sums N_TERMS products from
// multi_8 into one result. The result is returned over a valid/ready handshake.
// Ports:
//   clk, rst (sync, active-high), clr (sync abort of the partial sum)
//   in_valid/in_ready, a, b   : operand-pair handshake (one term per clk)
//   out_valid/out_ready       : result handshake
//   out_sum [ACC_W-1:0]       : accumulated sum
//   out_ovf                   : a carry out of ACC_W occurred for this result
// Macros: MAC_SATURATE_EN -- when defined, the accumulator clamps at all-ones
//   on carry-out. When undefined, the accumulator wraps modulo 2^ACC_W.
module mac_accum_8
   import mac_pkg::*;
#(
   parameter int N_TERMS = 4,
   parameter int ACC_W   = 18
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  a,
   input  logic [OP_W-1:0]  b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic             out_ovf
);

   localparam int            CW       = cnt_w(N_TERMS);
   localparam logic [CW-1:0] CNT_LAST = CW'(N_TERMS - 1);

   state_e            state_q, state_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [ACC_W-1:0]  sum_q, sum_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic              oovf_q, oovf_d;

   logic [PROD_W-1:0] prod_s;
   logic [ACC_W:0]    add_s;
   logic              carry_s;
   logic [ACC_W-1:0]  next_acc_s;
   logic              accept_s;

   multi_8 u_mul (
      .a (a),
      .b (b),
      .p (prod_s)
   );

   assign in_ready  = (state_q == ST_ACC) && !clr;
   assign out_valid = (state_q == ST_DONE);
   assign out_sum   = sum_q;
   assign out_ovf   = oovf_q;
   assign accept_s  = in_valid && in_ready;

   // Add with one extra bit so that the carry out of ACC_W is visible.
   always_comb begin
      add_s   = {1'b0, acc_q} + (ACC_W + 1)'(prod_s);
      carry_s = add_s[ACC_W];
`ifdef MAC_SATURATE_EN
      // Once the accumulator is at all-ones, any further nonzero product
      // carries again, so the clamp holds for the rest of the result.
      if (carry_s) begin
         next_acc_s = {ACC_W{1'b1}};
      end else begin
         next_acc_s = add_s[ACC_W-1:0];
      end
`else
      next_acc_s = add_s[ACC_W-1:0];
`endif
   end

   // Next-state and datapath update for the two-state collect/hold FSM.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      oovf_d  = oovf_q;
      case (state_q)
         ST_ACC: begin
            if (clr) begin
               acc_d = '0;
               cnt_d = '0;
               ovf_d = 1'b0;
            end else if (accept_s) begin
               acc_d = next_acc_s;
               ovf_d = ovf_q | carry_s;
               if (cnt_q == CNT_LAST) begin
                  sum_d   = next_acc_s;
                  oovf_d  = ovf_q | carry_s;
                  cnt_d   = '0;
                  state_d = ST_DONE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else begin
               acc_d = acc_q;
            end
         end
         ST_DONE: begin
            // clr is ignored here, so a completed result is never dropped.
            if (out_ready) begin
               acc_d   = '0;
               ovf_d   = 1'b0;
               state_d = ST_ACC;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_ACC;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_ACC;
         acc_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         oovf_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         oovf_q  <= oovf_d;
      end
   end

endmodule

// File: tb/tb_mac_accum_8.sv
// Testbench for mac_accum_8. It drives three instances:
//   dut 0: defaults (N_TERMS=4, ACC_W=18)
//   dut 1: N_TERMS=2, ACC_W=16 (overflow case)
//   dut 2: N_TERMS=1, ACC_W=18 (every accept completes)
// A behavioural model tracks collected terms and the true sum for each
// instance. A compare process checks the outputs on every falling edge.
// Directed sequences add literal expectations.
// Honours MAC_SATURATE_EN for the expected overflow behaviour.
module tb_mac_accum_8;

   logic        clk = 1'b0;
   logic        rst_v      [3];
   logic        clr_v      [3];
   logic        in_valid_v [3];
   logic        out_ready_v[3];
   logic [7:0]  a_v        [3];
   logic [7:0]  b_v        [3];
   logic        in_ready_o [3];
   logic        out_valid_o[3];
   logic        out_ovf_o  [3];
   logic [17:0] sum_o      [3];
   logic [17:0] sum0_s;
   logic [15:0] sum1_s;
   logic [17:0] sum2_s;

   int checks = 0;
   int errors = 0;

   // Model state, per instance.
   bit     m_busy [3];
   int     m_terms[3];
   longint m_sum  [3];
   longint m_res  [3];
   bit     m_ovf  [3];

   always #5 clk = ~clk;

   mac_accum_8 #(.N_TERMS(4), .ACC_W(18)) dut0 (
      .clk(clk), .rst(rst_v[0]), .clr(clr_v[0]), .in_valid(in_valid_v[0]),
      .in_ready(in_ready_o[0]), .a(a_v[0]), .b(b_v[0]), .out_valid(out_valid_o[0]),
      .out_ready(out_ready_v[0]), .out_sum(sum0_s), .out_ovf(out_ovf_o[0]));
   mac_accum_8 #(.N_TERMS(2), .ACC_W(16)) dut1 (
      .clk(clk), .rst(rst_v[1]), .clr(clr_v[1]), .in_valid(in_valid_v[1]),
      .in_ready(in_ready_o[1]), .a(a_v[1]), .b(b_v[1]), .out_valid(out_valid_o[1]),
      .out_ready(out_ready_v[1]), .out_sum(sum1_s), .out_ovf(out_ovf_o[1]));
   mac_accum_8 #(.N_TERMS(1), .ACC_W(18)) dut2 (
      .clk(clk), .rst(rst_v[2]), .clr(clr_v[2]), .in_valid(in_valid_v[2]),
      .in_ready(in_ready_o[2]), .a(a_v[2]), .b(b_v[2]), .out_valid(out_valid_o[2]),
      .out_ready(out_ready_v[2]), .out_sum(sum2_s), .out_ovf(out_ovf_o[2]));

   assign sum_o[0] = sum0_s;
   assign sum_o[1] = {2'b00, sum1_s};
   assign sum_o[2] = sum2_s;

   function automatic int n_of(input int d);
      case (d)
         0: return 4;
         1: return 2;
         default: return 1;
      endcase
   endfunction

   function automatic int w_of(input int d);
      case (d)
         1: return 16;
         default: return 18;
      endcase
   endfunction

   task automatic chk(input string nm, input int d, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s dut%0d: got %0d expected %0d at %0t", nm, d, act, exp, $time);
      end
   endtask

   // Model: collect products, then decide the result from the true sum.
   always @(posedge clk) begin
      for (int d = 0; d < 3; d++) begin
         longint maxv;
         maxv = (longint'(1) << w_of(d)) - 1;
         if (rst_v[d]) begin
            m_busy[d] = 1'b0; m_terms[d] = 0; m_sum[d] = 0; m_res[d] = 0; m_ovf[d] = 1'b0;
         end else if (m_busy[d]) begin
            if (out_ready_v[d]) m_busy[d] = 1'b0;
         end else if (clr_v[d]) begin
            m_terms[d] = 0; m_sum[d] = 0;
         end else if (in_valid_v[d]) begin
            m_sum[d] += longint'(a_v[d]) * longint'(b_v[d]);
            m_terms[d]++;
            if (m_terms[d] == n_of(d)) begin
`ifdef MAC_SATURATE_EN
               m_res[d] = (m_sum[d] > maxv) ? maxv : m_sum[d];
`else
               m_res[d] = m_sum[d] % (maxv + 1);
`endif
               m_ovf[d]   = (m_sum[d] > maxv);
               m_busy[d]  = 1'b1;
               m_terms[d] = 0;
               m_sum[d]   = 0;
            end
         end
      end
   end

   // Compare process: handshake outputs every cycle, and the result while it is held.
   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         chk("in_ready", d, longint'(in_ready_o[d]), longint'(!m_busy[d] && !clr_v[d]));
         chk("out_valid", d, longint'(out_valid_o[d]), longint'(m_busy[d]));
         if (m_busy[d]) begin
            chk("out_sum", d, longint'(sum_o[d]), m_res[d]);
            chk("out_ovf", d, longint'(out_ovf_o[d]), longint'(m_ovf[d]));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one term and hold it until it is accepted. Returns just after the accepting edge.
   task automatic send(input int d, input int av, input int bv);
      bit ok;
      ok = 1'b0;
      a_v[d] = 8'(av); b_v[d] = 8'(bv); in_valid_v[d] = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         ok = in_ready_o[d];
         step();
         if (ok) break;
      end
      if (!ok) begin
         errors++;
         $display("FAIL accept_timeout dut%0d: got no accept expected accept", d);
      end
   endtask

   task automatic idle(input int d);
      in_valid_v[d] = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int d = 0; d < 3; d++) begin
         rst_v[d] = 1'b1; clr_v[d] = 1'b0; in_valid_v[d] = 1'b0;
         out_ready_v[d] = 1'b1; a_v[d] = 8'd0; b_v[d] = 8'd0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) rst_v[d] = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk("rst_out_valid", d, longint'(out_valid_o[d]), 0);
         chk("rst_out_sum", d, longint'(sum_o[d]), 0);
         chk("rst_out_ovf", d, longint'(out_ovf_o[d]), 0);
         chk("rst_in_ready", d, longint'(in_ready_o[d]), 1);
      end
      step();

      // 1: back-to-back terms, result valid for one cycle after the 4th accept
      send(0, 1, 1); send(0, 3, 3); send(0, 17, 17); send(0, 20, 50); idle(0);
      @(negedge clk);
      chk("t1_valid", 0, longint'(out_valid_o[0]), 1);
      chk("t1_sum", 0, longint'(sum_o[0]), 1299);
      chk("t1_ovf", 0, longint'(out_ovf_o[0]), 0);
      @(negedge clk);
      chk("t1_valid_drop", 0, longint'(out_valid_o[0]), 0);
      step();

      // 2: result held under backpressure
      out_ready_v[0] = 1'b0;
      for (int i = 0; i < 4; i++) send(0, 100, 100);
      idle(0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t2_hold_valid", 0, longint'(out_valid_o[0]), 1);
         chk("t2_hold_sum", 0, longint'(sum_o[0]), 40000);
         chk("t2_hold_in_ready", 0, longint'(in_ready_o[0]), 0);
      end
      step();
      out_ready_v[0] = 1'b1;
      step();
      @(negedge clk);
      chk("t2_back_valid", 0, longint'(out_valid_o[0]), 0);
      chk("t2_back_in_ready", 0, longint'(in_ready_o[0]), 1);
      step();

      // 3: overflow at ACC_W=16, N_TERMS=2
      send(1, 255, 255); send(1, 255, 255); idle(1);
      @(negedge clk);
      chk("t3_valid", 1, longint'(out_valid_o[1]), 1);
`ifdef MAC_SATURATE_EN
      chk("t3_sum", 1, longint'(sum_o[1]), 65535);
`else
      chk("t3_sum", 1, longint'(sum_o[1]), 64514);
`endif
      chk("t3_ovf", 1, longint'(out_ovf_o[1]), 1);
      step();

      // 4: clr discards the partial sum and blocks the accept in that cycle
      send(0, 10, 10); send(0, 5, 5);
      clr_v[0] = 1'b1; a_v[0] = 8'd7; b_v[0] = 8'd7; in_valid_v[0] = 1'b1;
      @(negedge clk);
      chk("t4_clr_in_ready", 0, longint'(in_ready_o[0]), 0);
      step();
      clr_v[0] = 1'b0;
      for (int i = 0; i < 4; i++) send(0, 2, 3);
      idle(0);
      @(negedge clk);
      chk("t4_sum", 0, longint'(sum_o[0]), 24);
      step();

      // 5: reset in the middle of a result
      for (int i = 0; i < 3; i++) send(0, 1, 1);
      idle(0);
      rst_v[0] = 1'b1;
      step();
      rst_v[0] = 1'b0;
      @(negedge clk);
      chk("t5_rst_valid", 0, longint'(out_valid_o[0]), 0);
      chk("t5_rst_sum", 0, longint'(sum_o[0]), 0);
      chk("t5_rst_ovf", 0, longint'(out_ovf_o[0]), 0);
      step();
      for (int i = 0; i < 4; i++) send(0, 1, 2);
      idle(0);
      @(negedge clk);
      chk("t5_sum", 0, longint'(sum_o[0]), 8);
      chk("t5_ovf", 0, longint'(out_ovf_o[0]), 0);
      step();

      // 6: N_TERMS=1, each accept produces a result
      send(2, 12, 12); idle(2);
      @(negedge clk);
      chk("t6_sum_a", 2, longint'(sum_o[2]), 144);
      chk("t6_in_ready_a", 2, longint'(in_ready_o[2]), 0);
      step();
      send(2, 255, 1); idle(2);
      @(negedge clk);
      chk("t6_sum_b", 2, longint'(sum_o[2]), 255);
      chk("t6_in_ready_b", 2, longint'(in_ready_o[2]), 0);
      step();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
